// File: rtl/pwr_seq_ctrl.sv
// pwr_seq_ctrl: power sequencer for one switchable domain.
//
// Drives clock enable, isolation, retention save/restore, domain reset and the
// power switch in a fixed order. Handles the cold power-up after reset and every
// sleep/wake cycle requested through sleep_req.
//
// Configuration macro: PSEQ_RETENTION_EN
//   defined   - SAVE/RESTORE steps present, save/restore pulse for one cycle
//   undefined - SAVE/RESTORE steps removed, save/restore tied to 0
//
// Parameters:
//   STEP_CYCLES - cycles spent in each timed sequencing step (>= 1)
//   PG_TIMEOUT  - max cycles to wait for pwr_good in WAIT_PG (>= 1)
//
// Ports:
//   clk          in  controller clock
//   rst          in  asynchronous active-low reset
//   sleep_req    in  level request: 1 = sleep, 0 = run
//   pwr_good     in  power-switch acknowledge (already synchronised)
//   pwr_en       out power switch enable
//   iso_en       out isolation clamp enable
//   save         out retention save pulse
//   restore      out retention restore pulse
//   dom_rst_n    out domain reset, active-low
//   clk_en       out domain clock-gate enable
//   active       out domain usable
//   sleep_ack    out domain fully powered down
//   err_timeout  out sticky power-good timeout flag
module pwr_seq_ctrl #(
   parameter int unsigned STEP_CYCLES = 2,
   parameter int unsigned PG_TIMEOUT  = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic sleep_req,
   input  logic pwr_good,
   output logic pwr_en,
   output logic iso_en,
   output logic save,
   output logic restore,
   output logic dom_rst_n,
   output logic clk_en,
   output logic active,
   output logic sleep_ack,
   output logic err_timeout
);

   localparam int unsigned CntMax = (STEP_CYCLES > PG_TIMEOUT) ? STEP_CYCLES : PG_TIMEOUT;
   localparam int unsigned CntW   = $clog2(CntMax + 1);

   localparam logic [CntW-1:0] StepLast = CntW'(STEP_CYCLES - 1);
   localparam logic [CntW-1:0] PgLast   = CntW'(PG_TIMEOUT - 1);
   localparam logic [CntW-1:0] CntSat   = CntW'(CntMax);

   typedef enum logic [3:0] {
      StPwrOn,
      StWaitPg,
      StRstOff,
      StRestore,
      StIsoOff,
      StClkOn,
      StRun,
      StClkOff,
      StIsoOn,
      StSave,
      StRstOn,
      StPwrOff,
      StSleep
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            step_done;

   logic pwr_en_q, pwr_en_d;
   logic iso_en_q, iso_en_d;
   logic dom_rst_n_q, dom_rst_n_d;
   logic clk_en_q, clk_en_d;
   logic active_q, active_d;
   logic sleep_ack_q, sleep_ack_d;
   logic err_q, err_d;

`ifdef PSEQ_RETENTION_EN
   logic save_q, save_d;
   logic restore_q, restore_d;
   // Set until the first RUN: nothing has been saved yet, so RESTORE is skipped.
   logic cold_q, cold_d;
`endif

   assign step_done = (cnt_q == StepLast);

   always_comb begin
      state_d     = state_q;
      pwr_en_d    = pwr_en_q;
      iso_en_d    = iso_en_q;
      dom_rst_n_d = dom_rst_n_q;
      clk_en_d    = clk_en_q;
      active_d    = active_q;
      sleep_ack_d = sleep_ack_q;
      err_d       = err_q;
`ifdef PSEQ_RETENTION_EN
      save_d      = 1'b0;
      restore_d   = 1'b0;
      cold_d      = cold_q;
`endif

      unique case (state_q)
         StPwrOn:  state_d = StWaitPg;
         StWaitPg: begin
            if (pwr_good) begin
               state_d = StRstOff;
            end else if (cnt_q == PgLast) begin
               state_d = StSleep;
               err_d   = 1'b1;
            end
         end
         StRstOff: begin
            if (step_done) begin
`ifdef PSEQ_RETENTION_EN
               state_d = cold_q ? StIsoOff : StRestore;
`else
               state_d = StIsoOff;
`endif
            end
         end
`ifdef PSEQ_RETENTION_EN
         StRestore: if (step_done) state_d = StIsoOff;
`endif
         StIsoOff: if (step_done) state_d = StClkOn;
         StClkOn:  if (step_done) state_d = StRun;
         StRun:    if (sleep_req) state_d = StClkOff;
         StClkOff: if (step_done) state_d = StIsoOn;
         StIsoOn: begin
            if (step_done) begin
`ifdef PSEQ_RETENTION_EN
               state_d = StSave;
`else
               state_d = StRstOn;
`endif
            end
         end
`ifdef PSEQ_RETENTION_EN
         StSave:   if (step_done) state_d = StRstOn;
`endif
         StRstOn:  if (step_done) state_d = StPwrOff;
         StPwrOff: if (step_done) state_d = StSleep;
         // A timeout latches the FSM here until reset.
         StSleep:  if (!err_q && !sleep_req) state_d = StPwrOn;
         default:  state_d = StPwrOn;
      endcase

      // Outputs change only on the edge that enters a state.
      if (state_d != state_q) begin
         case (state_d)
            StPwrOn: begin
               pwr_en_d    = 1'b1;
               sleep_ack_d = 1'b0;
            end
            // Covers the cold boot, where reset leaves the FSM in PWR_ON with pwr_en low.
            StWaitPg:  pwr_en_d    = 1'b1;
            StRstOff:  dom_rst_n_d = 1'b1;
`ifdef PSEQ_RETENTION_EN
            StRestore: restore_d   = 1'b1;
            StSave:    save_d      = 1'b1;
`endif
            StIsoOff:  iso_en_d    = 1'b0;
            StClkOn:   clk_en_d    = 1'b1;
            StRun: begin
               active_d = 1'b1;
`ifdef PSEQ_RETENTION_EN
               cold_d   = 1'b0;
`endif
            end
            StClkOff: begin
               clk_en_d = 1'b0;
               active_d = 1'b0;
            end
            StIsoOn:   iso_en_d    = 1'b1;
            StRstOn:   dom_rst_n_d = 1'b0;
            StPwrOff:  pwr_en_d    = 1'b0;
            // pwr_en is already low on the normal path; this also drops it on timeout.
            StSleep: begin
               pwr_en_d    = 1'b0;
               sleep_ack_d = 1'b1;
            end
            default: ;
         endcase
         cnt_d = '0;
      end else begin
         cnt_d = (cnt_q == CntSat) ? cnt_q : cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StPwrOn;
         cnt_q       <= '0;
         pwr_en_q    <= 1'b0;
         iso_en_q    <= 1'b1;
         dom_rst_n_q <= 1'b0;
         clk_en_q    <= 1'b0;
         active_q    <= 1'b0;
         sleep_ack_q <= 1'b0;
         err_q       <= 1'b0;
`ifdef PSEQ_RETENTION_EN
         save_q      <= 1'b0;
         restore_q   <= 1'b0;
         cold_q      <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pwr_en_q    <= pwr_en_d;
         iso_en_q    <= iso_en_d;
         dom_rst_n_q <= dom_rst_n_d;
         clk_en_q    <= clk_en_d;
         active_q    <= active_d;
         sleep_ack_q <= sleep_ack_d;
         err_q       <= err_d;
`ifdef PSEQ_RETENTION_EN
         save_q      <= save_d;
         restore_q   <= restore_d;
         cold_q      <= cold_d;
`endif
      end
   end

   assign pwr_en      = pwr_en_q;
   assign iso_en      = iso_en_q;
   assign dom_rst_n   = dom_rst_n_q;
   assign clk_en      = clk_en_q;
   assign active      = active_q;
   assign sleep_ack   = sleep_ack_q;
   assign err_timeout = err_q;
`ifdef PSEQ_RETENTION_EN
   assign save        = save_q;
   assign restore     = restore_q;
`else
   assign save        = 1'b0;
   assign restore     = 1'b0;
`endif

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// tb_pwr_seq_ctrl: directed bench for pwr_seq_ctrl (STEP_CYCLES=2, PG_TIMEOUT=10).
// Expected output vectors are derived from the sequencing timelines and queued per
// clock edge; each edge's outputs are compared at the following falling edge.
module tb_pwr_seq_ctrl;

   localparam int S = 2;
`ifdef PSEQ_RETENTION_EN
   localparam int R = 1;
`else
   localparam int R = 0;
`endif

   logic clk;
   logic rst;
   logic sleep_req;
   logic pwr_good;
   logic pwr_en, iso_en, save, restore, dom_rst_n, clk_en, active, sleep_ack, err_timeout;
   logic [8:0] obs;

   typedef struct {
      int         cyc;
      logic [8:0] vec;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   checks;
   int   errors;

   pwr_seq_ctrl #(
      .STEP_CYCLES(S),
      .PG_TIMEOUT (10)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .sleep_req  (sleep_req),
      .pwr_good   (pwr_good),
      .pwr_en     (pwr_en),
      .iso_en     (iso_en),
      .save       (save),
      .restore    (restore),
      .dom_rst_n  (dom_rst_n),
      .clk_en     (clk_en),
      .active     (active),
      .sleep_ack  (sleep_ack),
      .err_timeout(err_timeout)
   );

   assign obs = {pwr_en, iso_en, save, restore, dom_rst_n, clk_en, active, sleep_ack,
                 err_timeout};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Order: pwr_en iso_en save restore dom_rst_n clk_en active sleep_ack err_timeout
   function automatic logic [8:0] mk(input logic pe, input logic iso, input logic sv,
                                     input logic rs, input logic drn, input logic ce,
                                     input logic act, input logic ack, input logic err);
      return {pe, iso, sv, rs, drn, ce, act, ack, err};
   endfunction

   logic [8:0] rst_v, pu_v, run_v, slp_v, err_v;

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %0b expected %0b", tag, o, e);
      end
   endtask

   task automatic push(input int c, input logic [8:0] v);
      exp_t e;
      e.cyc = c;
      e.vec = v;
      sb.push_back(e);
   endtask

   task automatic hold(input int c0, input int c1, input logic [8:0] v);
      for (int c = c0; c <= c1; c++) push(c, v);
   endtask

   // Power-up from pwr_good sampled at edge p; returns the edge where active rises.
   task automatic push_pu(input int p, input bit warm, output int act);
      int iso_off, clk_on;
      bit rs;
      rs      = warm && (R != 0);
      iso_off = p + (rs ? 2 * S : S);
      clk_on  = iso_off + S;
      act     = clk_on + S;
      for (int c = p; c <= act; c++)
         push(c, mk(1'b1, c < iso_off, 1'b0, rs && (c == p + S), 1'b1, c >= clk_on,
                    c >= act, 1'b0, 1'b0));
   endtask

   // Power-down from sleep_req sampled at edge t; returns the edge where sleep_ack rises.
   task automatic push_pd(input int t, output int e);
      int rst_on, pwr_off;
      rst_on  = t + (2 + R) * S;
      pwr_off = rst_on + S;
      e       = pwr_off + S;
      for (int c = t; c <= e; c++)
         push(c, mk(c < pwr_off, c >= t + S, (R != 0) && (c == t + 2 * S), 1'b0, c < rst_on,
                    1'b0, 1'b0, c >= e, 1'b0));
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         chk($sformatf("edge%0d", e.cyc), {23'd0, obs}, {23'd0, e.vec});
      end
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end expected end of run");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int c, p, a, t, e;
      rst_v = mk(0, 1, 0, 0, 0, 0, 0, 0, 0);
      pu_v  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0);
      run_v = mk(1, 0, 0, 0, 1, 1, 1, 0, 0);
      slp_v = mk(0, 1, 0, 0, 0, 0, 0, 1, 0);
      err_v = mk(0, 1, 0, 0, 0, 0, 0, 1, 1);
      checks    = 0;
      errors    = 0;
      cyc       = 0;
      rst       = 1'b0;
      sleep_req = 1'b0;
      pwr_good  = 1'b0;

      // Reset values, also while clocks run with reset held.
      @(negedge clk);
      chk("reset", {23'd0, obs}, {23'd0, rst_v});
      hold(cyc + 1, cyc + 2, rst_v);
      run_to(cyc + 2);

      // Cold boot: pwr_en on first edge, pwr_good 5 cycles later, no restore.
      rst = 1'b1;
      c   = cyc;
      hold(c + 1, c + 5, pu_v);
      run_to(c + 5);
      pwr_good = 1'b1;
      push_pu(c + 6, 1'b0, a);
      run_to(a);
      pwr_good = 1'b0;   // ignored outside WAIT_PG
      hold(a + 1, a + 3, run_v);
      run_to(a + 3);

      // Power-down to SLEEP; sleep_req held high keeps it there.
      sleep_req = 1'b1;
      t = cyc + 1;
      push_pd(t, e);
      hold(e + 1, e + 3, slp_v);
      run_to(e + 3);

      // Warm wake; pwr_good already high must not shorten PWR_ON/WAIT_PG.
      sleep_req = 1'b0;
      pwr_good  = 1'b1;
      c = cyc;
      hold(c + 1, c + 2, pu_v);
      push_pu(c + 3, 1'b1, a);
      hold(a + 1, a + 2, run_v);
      run_to(a + 2);

      // sleep_req dropped during ISO_ON: power-down completes, then wakes.
      sleep_req = 1'b1;
      t = cyc + 1;
      push_pd(t, e);
      run_to(t + S);
      sleep_req = 1'b0;
      hold(e + 1, e + 2, pu_v);
      push_pu(e + 3, 1'b1, a);
      hold(a + 1, a + 1, run_v);
      run_to(a + 1);

      // Reset pulsed during RST_ON: immediate reset values, then a cold boot.
      sleep_req = 1'b1;
      t = cyc + 1;
      push_pd(t, e);
      run_to(t + (2 + R) * S);
      rst = 1'b0;
      #1;
      chk("rst_mid_seq", {23'd0, obs}, {23'd0, rst_v});
      sb.delete();
      sleep_req = 1'b0;
      push(cyc + 1, rst_v);
      run_to(cyc + 1);
      rst      = 1'b1;
      pwr_good = 1'b1;
      c = cyc;
      push(c + 1, pu_v);
      push_pu(c + 2, 1'b0, a);
      hold(a + 1, a + 2, run_v);
      run_to(a + 2);

      // pwr_good timeout: err latched, SLEEP held regardless of sleep_req.
      pwr_good  = 1'b0;
      sleep_req = 1'b1;
      t = cyc + 1;
      push_pd(t, e);
      run_to(e);
      sleep_req = 1'b0;
      hold(e + 1, e + 11, pu_v);
      push(e + 12, err_v);
      hold(e + 13, e + 15, err_v);
      run_to(e + 15);
      sleep_req = 1'b1;
      hold(cyc + 1, cyc + 3, err_v);
      run_to(cyc + 3);
      sleep_req = 1'b0;
      pwr_good  = 1'b1;
      hold(cyc + 1, cyc + 4, err_v);
      run_to(cyc + 4);

      chk("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwr_seq_ctrl.md
# pwr_seq_ctrl

Power-domain sequencer for one switchable domain. It takes the synchronised reset from the reset synchronizer on `rst` and drives the domain's clock enable, isolation, retention save/restore, domain reset and power switch in a fixed order. It handles the cold power-up after system reset and every sleep/wake cycle requested by the system controller.

## Interface

Parameters:
- `STEP_CYCLES`, default 2: cycles spent in each sequencing step. Legal range is 1 or more.
- `PG_TIMEOUT`, default 255: maximum cycles to wait for `pwr_good` after the switch is enabled. Legal range is 1 or more.

Ports:
- `clk` in 1: domain-controller clock.
- `rst` in 1: reset, asynchronous, active-low. Clock `clk`.
- `sleep_req` in 1: level request, synchronous to `clk`. 1 = enter sleep, 0 = run.
- `pwr_good` in 1: power-switch ack, already synchronised to `clk`.
- `pwr_en` out 1: power switch enable.
- `iso_en` out 1: isolation clamp enable.
- `save` out 1: retention save pulse.
- `restore` out 1: retention restore pulse.
- `dom_rst_n` out 1: domain reset, active-low.
- `clk_en` out 1: domain clock-gate enable.
- `active` out 1: the domain is usable.
- `sleep_ack` out 1: the domain is fully powered down.
- `err_timeout` out 1: sticky power-good timeout flag.

## Operation

- FSM states: `PWR_ON`, `WAIT_PG`, `RST_OFF`, `RESTORE`, `ISO_OFF`, `CLK_ON`, `RUN`, `CLK_OFF`, `ISO_ON`, `SAVE`, `RST_ON`, `PWR_OFF`, `SLEEP`.
- Every output is a register, updated on the same edge that enters a state. Outputs are glitch-free.
- Reset values: state `PWR_ON`, `pwr_en`=0, `iso_en`=1, `dom_rst_n`=0, `clk_en`=0, `save`=0, `restore`=0, `active`=0, `sleep_ack`=0, `err_timeout`=0. Internal `cold`=1.
- Power-down path: `RUN` (`sleep_req`=1) → `CLK_OFF` (`clk_en`=0, `active`=0) → `ISO_ON` (`iso_en`=1) → `SAVE` → `RST_ON` (`dom_rst_n`=0) → `PWR_OFF` (`pwr_en`=0) → `SLEEP` (`sleep_ack`=1).
- Power-up path: `SLEEP` (`sleep_req`=0, `sleep_ack`→0) → `PWR_ON` (`pwr_en`=1) → `WAIT_PG` → `RST_OFF` (`dom_rst_n`=1) → `RESTORE` → `ISO_OFF` (`iso_en`=0) → `CLK_ON` (`clk_en`=1) → `RUN` (`active`=1, `cold` cleared).
- `save` and `restore` are 1 during the first cycle of `SAVE` and `RESTORE` only.
- `RESTORE` is skipped while `cold`=1. After reset there is no retained state to restore.
- `sleep_req` is sampled only in `RUN` and `SLEEP`. Changes during a sequence are ignored; the sequence always completes first.
- `pwr_good` is sampled only in `WAIT_PG`. Its value in any other state has no effect.
- Timeout: if `WAIT_PG` lasts `PG_TIMEOUT` cycles without `pwr_good`, then `err_timeout`=1, `pwr_en`=0 and the FSM goes to `SLEEP`. While `err_timeout`=1 the FSM stays in `SLEEP` regardless of `sleep_req`. Only `rst` clears it.
- Counter width is `$clog2(max(STEP_CYCLES,PG_TIMEOUT)+1)`. The counter is cleared on every state entry.

## Timing

- Timed steps: each of `CLK_OFF`, `ISO_ON`, `SAVE`, `RST_ON`, `PWR_OFF`, `RST_OFF`, `RESTORE`, `ISO_OFF` and `CLK_ON` lasts exactly `STEP_CYCLES` cycles.
- `PWR_ON` lasts 1 cycle.
- `WAIT_PG` lasts at least 1 cycle. It exits on the edge that samples `pwr_good`=1.
- Power-down timeline, with `sleep_req`=1 sampled at edge t in `RUN`:
  - `clk_en`=0 at t.
  - `iso_en`=1 at t+S.
  - `save` high at t+2S for 1 cycle.
  - `dom_rst_n`=0 at t+3S.
  - `pwr_en`=0 at t+4S.
  - `sleep_ack`=1 at t+5S.
  - S = `STEP_CYCLES`.
- Power-up timeline, with `pwr_good`=1 sampled at edge p:
  - `dom_rst_n`=1 at p.
  - `restore` at p+S (warm wake only).
  - `iso_en`=0 at p+2S (warm) or p+S (cold).
  - `clk_en`=1 at p+3S (warm) or p+2S (cold).
  - `active`=1 at p+4S (warm) or p+3S (cold).
- Cold boot: `pwr_en`=1 on the first edge after `rst` deasserts.
- `rst` asserted mid-sequence: all outputs return to their reset values immediately (asynchronous), and `cold`=1.

## Configuration

- Macro `PSEQ_RETENTION_EN`.
- Defined: `SAVE` and `RESTORE` exist as described above.
- Undefined: both states are removed, and `save`/`restore` are tied to 0.
  - Power-down: `sleep_ack` at t+4S.
  - Warm power-up: equals cold timing, `active` at p+3S.

## Test plan

- Cold boot, S=2, `pwr_good` raised 5 cycles after `pwr_en` → `dom_rst_n`=1 at p, `iso_en`=0 at p+2, `clk_en`=1 at p+4, `active`=1 at p+6. No `restore` pulse.
- `sleep_req`=1 in `RUN` at t → `clk_en`=0 at t, `iso_en`=1 at t+2, `save` pulse at t+4, `dom_rst_n`=0 at t+6, `pwr_en`=0 at t+8, `sleep_ack`=1 at t+10.
- Warm wake from `SLEEP`, `pwr_good` at p → `restore` single pulse at p+2, `active`=1 at p+8.
- `sleep_req` toggled 1→0 during `ISO_ON` → full power-down still completes to `SLEEP`, then power-up starts.
- `pwr_good` held 0 with `PG_TIMEOUT`=10 → `err_timeout`=1 and `pwr_en`=0 after 10 `WAIT_PG` cycles. `SLEEP` is held with `sleep_req`=0.
- `rst` pulsed low during `RST_ON` → all outputs are at reset values within the same cycle, and a cold boot sequence follows.
